// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bus of the branch predictor.
// The pipeline side uses the master modport; the predictor uses slave.
interface branch_predictor_if;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        BranchE;
   logic        BranchTakenE;
   logic [31:0] PCE;
   logic [31:0] BranchTargetE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        MispredictE;
   logic [31:0] RecoverPCE;

   modport master (
      output PCF, BranchE, BranchTakenE, PCE, BranchTargetE, PredTakenE, PredTargetE,
      input  PredTakenF, PredTargetF, MispredictE, RecoverPCE
   );

   modport slave (
      input  PCF, BranchE, BranchTakenE, PCE, BranchTargetE, PredTakenE, PredTargetE,
      output PredTakenF, PredTargetF, MispredictE, RecoverPCE
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup at fetch is combinational; training happens at execute on BranchE.
// Optional feature: define BP_STATS_EN to add saturating BranchCount and
// MispredCount statistics outputs.
module branch_predictor #(
   parameter int unsigned IDX_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   branch_predictor_if.slave bp
`ifdef BP_STATS_EN
   ,
   output logic [15:0] BranchCount,
   output logic [15:0] MispredCount
`endif
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned TAG_W   = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;

   logic [IDX_W-1:0] idx_e;
   logic [TAG_W-1:0] tag_e;
   logic             hit_e;
   logic [1:0]       ctr_e;
   logic [1:0]       ctr_next;

   // Fetch lookup; gated by reset so the prediction is safe before the first edge
   always_comb begin
      idx_f          = bp.PCF[IDX_W+1:2];
      tag_f          = bp.PCF[31:IDX_W+2];
      hit_f          = reset & valid_q[idx_f] & (tag_q[idx_f] == tag_f);
      bp.PredTakenF  = hit_f & ctr_q[idx_f][1];
      bp.PredTargetF = hit_f ? target_q[idx_f] : bp.PCF + 32'd4;
   end

   // Execute-side resolution: mispredict detection and the corrected next PC
   always_comb begin
      bp.MispredictE = bp.BranchE &
                       ((bp.PredTakenE != bp.BranchTakenE) |
                        (bp.PredTakenE & bp.BranchTakenE &
                         (bp.PredTargetE != bp.BranchTargetE)));
      bp.RecoverPCE  = bp.BranchTakenE ? bp.BranchTargetE : bp.PCE + 32'd4;
   end

   // Training-side probe of the entry addressed by the resolving branch
   always_comb begin
      idx_e    = bp.PCE[IDX_W+1:2];
      tag_e    = bp.PCE[31:IDX_W+2];
      hit_e    = valid_q[idx_e] & (tag_q[idx_e] == tag_e);
      ctr_e    = ctr_q[idx_e];
      ctr_next = ctr_e;
      if (bp.BranchTakenE) begin
         if (ctr_e != 2'b11) ctr_next = ctr_e + 2'd1;
      end else begin
         if (ctr_e != 2'b00) ctr_next = ctr_e - 2'd1;
      end
   end

   // Table update: train on hit, allocate on taken miss, ignore not-taken miss
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (bp.BranchE) begin
         if (hit_e) begin
            ctr_q[idx_e] <= ctr_next;
            if (bp.BranchTakenE) target_q[idx_e] <= bp.BranchTargetE;
         end else if (bp.BranchTakenE) begin
            valid_q[idx_e]  <= 1'b1;
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= bp.BranchTargetE;
            ctr_q[idx_e]    <= 2'b10;
         end
      end
   end

`ifdef BP_STATS_EN
   // Saturating statistics of resolved branches and mispredictions
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BranchCount  <= '0;
         MispredCount <= '0;
      end else begin
         if (bp.BranchE && BranchCount != '1)      BranchCount  <= BranchCount + 16'd1;
         if (bp.MispredictE && MispredCount != '1) MispredCount <= MispredCount + 16'd1;
      end
   end
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, SHALL set the table size to 2**IDX_W entries, indexed by PC[IDX_W+1:2].
REQ-002 clk  input  1  SHALL be the single clock; every state element updates on the rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 PCF  input  32  SHALL carry the fetch-stage PC to look up.
REQ-005 PredTakenF  output  1  SHALL be the taken prediction for PCF; it drives the PC-select mux.
REQ-006 PredTargetF  output  32  SHALL be the predicted target for PCF.
REQ-007 BranchE  input  1  SHALL mark a resolved branch in execute; it is already qualified by flush and condition-valid.
REQ-008 BranchTakenE  input  1  SHALL be the resolved direction.
REQ-009 PCE  input  32  SHALL be the PC of the resolving branch.
REQ-010 BranchTargetE  input  32  SHALL be the resolved target (ALU result).
REQ-011 PredTakenE, PredTargetE  input  1/32  SHALL be the prediction made for that branch, piped from fetch.
REQ-012 MispredictE  output  1  SHALL request a flush and redirect.
REQ-013 RecoverPCE  output  32  SHALL be the correct next PC.

Function
REQ-014 Each entry SHALL hold: valid (1), tag PC[31:IDX_W+2], target (32), 2-bit saturating counter.
REQ-015 Lookup SHALL be combinational and use the pre-edge table state: hit = valid & tag match; PredTakenF = hit & counter[1]; PredTargetF = hit ? target : PCF+4.
REQ-016 MispredictE SHALL equal BranchE & ((PredTakenE != BranchTakenE) | (PredTakenE & BranchTakenE & PredTargetE != BranchTargetE)), and SHALL be 0 when BranchE=0.
REQ-017 RecoverPCE SHALL be BranchTakenE ? BranchTargetE : PCE+4; all arithmetic is modulo 2**32.
REQ-018 Update SHALL occur only on a clock edge with BranchE=1, at index PCE[IDX_W+1:2].
REQ-019 On update with a hit, the counter SHALL increment on taken, saturating at 3, and decrement on not-taken, saturating at 0.
REQ-020 On update with a hit and taken, the target SHALL be overwritten with BranchTargetE.
REQ-021 On update with a miss and taken, the entry SHALL be allocated (replacing any occupant): valid=1, tag, target=BranchTargetE, counter=2.
REQ-022 On update with a miss and not-taken, the table SHALL be left unchanged.
REQ-023 When a lookup and an update hit the same index in one cycle, the lookup SHALL return the old contents; the new contents SHALL be visible from the next cycle.
REQ-024 The block SHALL need no stall input: lookup is stateless, and a stalled fetch simply re-reads.

Reset
REQ-025 While reset=0, all valid bits SHALL be 0, all counters 1, and all targets and tags 0.
REQ-026 While reset=0, PredTakenF SHALL be 0 and PredTargetF SHALL be PCF+4.
REQ-027 Reset asserted during an update edge SHALL win, and no entry SHALL be written.

Configuration
REQ-028 With macro BP_STATS_EN defined, the block SHALL add outputs BranchCount[15:0] and MispredCount[15:0].
REQ-029 BranchCount SHALL increment on each BranchE edge, and MispredCount on each MispredictE edge.
REQ-030 Both counters SHALL saturate at 16'hFFFF and SHALL reset to 0.
REQ-031 Without BP_STATS_EN, these ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Release reset, then hold PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-033 BranchE=1, taken, PCE=0x100, target 0x200, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x200; next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x200.
REQ-034 Three not-taken updates at 0x100 -> counter goes 2->1->0->0; PredTakenF=0 after the first; MispredictE=0 on the updates once the prediction is not-taken.
REQ-035 Aliasing: allocate 0x100, then look up 0x140 (same index for IDX_W=4, different tag) -> PredTakenF=0.
REQ-036 Lookup and update at 0x100 in the same cycle -> old prediction that cycle, new one the next cycle.
REQ-037 With BP_STATS_EN: 70000 branches -> BranchCount holds at 0xFFFF; pulse reset low mid-stream -> both counters read 0 and table valid bits are 0.
